// File: rtl/parking_gate_controller_if.sv
// parking_gate_controller_if: request/ack handshake and occupancy status bundle for the barrier gate
interface parking_gate_controller_if;
    logic       entry_req;
    logic       exit_req;
    logic [2:0] exit_slot;
    logic       entry_ack;
    logic       entry_ok;
    logic [2:0] entry_slot;
    logic       exit_ack;
    logic       exit_ok;
    logic       gate_open;
    logic       busy;
    logic [7:0] slot_map;
    logic [3:0] empty;
    logic [3:0] parked;
    logic       full;

    modport master (
        output entry_req, exit_req, exit_slot,
        input  entry_ack, entry_ok, entry_slot, exit_ack, exit_ok,
        input  gate_open, busy, slot_map, empty, parked, full
    );

    modport slave (
        input  entry_req, exit_req, exit_slot,
        output entry_ack, entry_ok, entry_slot, exit_ack, exit_ok,
        output gate_open, busy, slot_map, empty, parked, full
    );
endinterface

// File: rtl/parking_gate_controller.sv
// parking_gate_controller: arbitrates entry/exit over one barrier, owns the 8-slot map (1 = empty)
module parking_gate_controller #(
    parameter int unsigned GATE_CYCLES = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    parking_gate_controller_if.slave    gi
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] GRANT = 2'd1;
    localparam logic [1:0] OPEN  = 2'd2;
    localparam logic [1:0] CLOSE = 2'd3;

    logic [1:0] state_q, state_d;
    logic [7:0] map_q, map_d;
    logic [7:0] cnt_q, cnt_d;
    logic [3:0] empty_q, empty_d;
    logic [3:0] parked_q, parked_d;
    logic       full_q, full_d;
    logic       last_exit_q, last_exit_d;
    logic       entry_ack_q, entry_ack_d;
    logic       exit_ack_q, exit_ack_d;
    logic       entry_ok_q, entry_ok_d;
    logic       exit_ok_q, exit_ok_d;
    logic [2:0] entry_slot_q, entry_slot_d;
    logic [2:0] low;
    logic       req, exit_win, grant_ok;

    assign req      = gi.entry_req | gi.exit_req;
    // on a tie exit wins when the park is full or when entry was served last
    assign exit_win = gi.exit_req & (~gi.entry_req | full_q | ~last_exit_q);
    assign grant_ok = entry_ack_q ? entry_ok_q : exit_ok_q;

    always_comb begin
        low = 3'd0;
        for (int i = 7; i >= 0; i--)
            if (map_q[i]) low = 3'(i);
        empty_d = 4'd0;
        for (int i = 0; i < 8; i++)
            empty_d = empty_d + {3'd0, map_q[i]};
        parked_d     = 4'd8 - empty_d;
        full_d       = (empty_d == 4'd0);
        state_d      = state_q;
        map_d        = map_q;
        cnt_d        = cnt_q;
        last_exit_d  = last_exit_q;
        entry_ack_d  = 1'b0;
        exit_ack_d   = 1'b0;
        entry_ok_d   = entry_ok_q;
        exit_ok_d    = exit_ok_q;
        entry_slot_d = entry_slot_q;
        case (state_q)
            IDLE: if (req) begin
                state_d     = GRANT;
                last_exit_d = exit_win;
                entry_ack_d = ~exit_win;
                exit_ack_d  = exit_win;
                if (exit_win) begin
                    exit_ok_d               = ~map_q[gi.exit_slot];
                    map_d[gi.exit_slot]     = 1'b1;
                end else begin
                    entry_ok_d   = |map_q;
                    entry_slot_d = low;
                    if (|map_q) map_d[low] = 1'b0;
                end
            end
            GRANT: begin
                state_d = grant_ok ? OPEN : CLOSE;
                cnt_d   = 8'(GATE_CYCLES);
            end
            OPEN: begin
                cnt_d   = cnt_q - 8'd1;
                state_d = (cnt_q == 8'd1) ? CLOSE : OPEN;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            map_q        <= 8'hFF;
            cnt_q        <= 8'd0;
            empty_q      <= 4'd8;
            parked_q     <= 4'd0;
            full_q       <= 1'b0;
            last_exit_q  <= 1'b0;
            entry_ack_q  <= 1'b0;
            exit_ack_q   <= 1'b0;
            entry_ok_q   <= 1'b0;
            exit_ok_q    <= 1'b0;
            entry_slot_q <= 3'd0;
        end else begin
            state_q      <= state_d;
            map_q        <= map_d;
            cnt_q        <= cnt_d;
            empty_q      <= empty_d;
            parked_q     <= parked_d;
            full_q       <= full_d;
            last_exit_q  <= last_exit_d;
            entry_ack_q  <= entry_ack_d;
            exit_ack_q   <= exit_ack_d;
            entry_ok_q   <= entry_ok_d;
            exit_ok_q    <= exit_ok_d;
            entry_slot_q <= entry_slot_d;
        end
    end

    assign gi.entry_ack  = entry_ack_q;
    assign gi.entry_ok   = entry_ok_q;
    assign gi.entry_slot = entry_slot_q;
    assign gi.exit_ack   = exit_ack_q;
    assign gi.exit_ok    = exit_ok_q;
    assign gi.gate_open  = (state_q == OPEN);
    assign gi.busy       = (state_q != IDLE);
    assign gi.slot_map   = map_q;
    assign gi.empty      = empty_q;
    assign gi.parked     = parked_q;
    assign gi.full       = full_q;
endmodule

// File: tb/tb_parking_gate_controller.sv
// tb_parking_gate_controller: directed checks of arbitration, slot assignment, gate timing and reset
module tb_parking_gate_controller;
    localparam int GC = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    parking_gate_controller_if gi();

    parking_gate_controller #(.GATE_CYCLES(GC)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .gi    (gi)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // counts cycles from `start` until busy drops and the gate cycles seen on the way
    task automatic wait_idle(input int start, input int exp_idle, input int exp_gate);
        int n = start;
        int g = 0;
        while (gi.busy === 1'b1 && n < 40) begin
            g += int'(gi.gate_open);
            @(negedge clk);
            n++;
        end
        chk("idle_cycle", n, exp_idle);
        chk("gate_cycles", g, exp_gate);
    endtask

    task automatic txn(input bit en, input bit ex, input bit hold, input logic [2:0] es,
                       input bit exp_exit, input bit exp_ok, input logic [2:0] exp_slot,
                       input logic [7:0] exp_map);
        gi.entry_req = en;
        gi.exit_req  = ex;
        gi.exit_slot = es;
        @(negedge clk);
        chk("entry_ack", gi.entry_ack, !exp_exit);
        chk("exit_ack", gi.exit_ack, exp_exit);
        chk("ok", exp_exit ? gi.exit_ok : gi.entry_ok, exp_ok);
        if (!exp_exit && exp_ok) chk("entry_slot", gi.entry_slot, exp_slot);
        chk("slot_map", gi.slot_map, exp_map);
        if (!hold) begin
            gi.entry_req = 1'b0;
            gi.exit_req  = 1'b0;
        end
        wait_idle(1, exp_ok ? GC + 3 : 3, exp_ok ? GC : 0);
    endtask

    initial begin
        gi.entry_req = 1'b0;
        gi.exit_req  = 1'b0;
        gi.exit_slot = 3'd0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_map", gi.slot_map, 8'hFF);
        chk("rst_empty", gi.empty, 8);
        chk("rst_parked", gi.parked, 0);
        chk("rst_full", gi.full, 0);
        chk("rst_gate", gi.gate_open, 0);
        chk("rst_busy", gi.busy, 0);
        chk("rst_acks", {gi.entry_ack, gi.exit_ack}, 0);

        // single entry with cycle-by-cycle count lag
        gi.entry_req = 1'b1;
        @(negedge clk);
        chk("e1_ack", gi.entry_ack, 1);
        chk("e1_ok", gi.entry_ok, 1);
        chk("e1_slot", gi.entry_slot, 0);
        chk("e1_map", gi.slot_map, 8'hFE);
        chk("e1_empty_lag", gi.empty, 8);
        chk("e1_gate_grant", gi.gate_open, 0);
        gi.entry_req = 1'b0;
        @(negedge clk);
        chk("e1_empty", gi.empty, 7);
        chk("e1_parked", gi.parked, 1);
        wait_idle(2, GC + 3, GC);

        // fill remaining slots in order
        for (int k = 1; k < 8; k++)
            txn(1, 0, 0, 3'd0, 0, 1, 3'(k), 8'(8'hFF << (k + 1)));
        chk("fill_full", gi.full, 1);
        chk("fill_empty", gi.empty, 0);
        chk("fill_parked", gi.parked, 8);
        txn(1, 0, 0, 3'd0, 0, 0, 3'd0, 8'h00);

        // full park: tie goes to exit, then entry reuses the freed slot
        txn(1, 1, 0, 3'd3, 1, 1, 3'd0, 8'h08);
        txn(1, 0, 0, 3'd0, 0, 1, 3'd3, 8'h00);

        // alternation with both held, exit to an already empty slot
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        txn(1, 1, 1, 3'd5, 1, 0, 3'd0, 8'hFF);
        txn(1, 1, 1, 3'd5, 0, 1, 3'd0, 8'hFE);
        txn(1, 1, 0, 3'd5, 1, 0, 3'd0, 8'hFE);
        txn(0, 1, 0, 3'd0, 1, 1, 3'd0, 8'hFF);

        // asynchronous reset in the middle of OPEN
        txn(1, 0, 0, 3'd0, 0, 1, 3'd0, 8'hFE);
        txn(1, 0, 0, 3'd0, 0, 1, 3'd1, 8'hFC);
        gi.entry_req = 1'b1;
        @(negedge clk);
        gi.entry_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("mid_gate_before", gi.gate_open, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_gate", gi.gate_open, 0);
        chk("mid_map", gi.slot_map, 8'hFF);
        chk("mid_busy", gi.busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        txn(1, 0, 0, 3'd0, 0, 1, 3'd0, 8'hFE);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/parking_gate_controller.md
# parking_gate_controller

Sequential controller for the car park's single shared barrier gate. It owns the 8-slot occupancy map. It arbitrates between entry and exit requesters, assigns the lowest free slot to each entering car, and releases the slot named by each exiting car. It also times the gate opening. Registered free/occupied counts for the display are derived from the map using the same convention as the capacity counter: map bit = 1 means the slot is empty.

## Interface
- GATE_CYCLES, 4, cycles gate_open stays high per accepted transaction; legal range 1..255
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- entry_req  in  1  level; car waiting at entry; held until entry_ack, dropped on the next edge after it
- exit_req  in  1  level; car waiting at exit; same handshake with exit_ack
- exit_slot  in  3  slot being vacated; sampled only when exit_req wins arbitration
- entry_ack  out  1  one-cycle pulse; entry request resolved
- entry_ok  out  1  valid with entry_ack; 1 = slot assigned, 0 = rejected (park full)
- entry_slot  out  3  valid with entry_ack and entry_ok; assigned slot index
- exit_ack  out  1  one-cycle pulse; exit request resolved
- exit_ok  out  1  valid with exit_ack; 1 = slot released, 0 = error (slot already empty)
- gate_open  out  1  barrier drive
- busy  out  1  high in every state except IDLE
- slot_map  out  8  occupancy map; bit i = 1 means slot i is empty
- empty  out  4  registered popcount of slot_map, 0..8
- parked  out  4  registered 8 − empty
- full  out  1  registered (empty == 0)

## Operation
- FSM states: IDLE, GRANT, OPEN, CLOSE.
- **IDLE:** requests are sampled only here. If there is no request, stay in IDLE. Otherwise pick a winner and go to GRANT.
- **Arbitration:**
  - Single request: it wins.
  - Both requests and full = 1: exit wins.
  - Both requests otherwise: the type opposite to the last acknowledged one wins. The last-served flag resets to "entry", so the first tie goes to exit. Every ack, including a reject, updates the flag.
- **Decision:** made at the IDLE→GRANT edge.
  - Entry, map ≠ 0: entry_slot = lowest-index set bit; that bit is cleared; ok = 1.
  - Entry, map = 0: ok = 0; map unchanged.
  - Exit, slot_map[exit_slot] = 0: the bit is set; ok = 1.
  - Exit, slot_map[exit_slot] = 1: ok = 0; map unchanged.
- **GRANT:** one cycle. The winning ack pulses with ok and slot registered. Next state is OPEN if ok = 1, otherwise CLOSE.
- **OPEN:** gate_open = 1 for exactly GATE_CYCLES cycles, counted by an 8-bit down-counter. Then go to CLOSE.
- **CLOSE:** one cycle with gate_open = 0, then IDLE. This guard cycle guarantees the requester has dropped req before the next IDLE sample.
- **Counts:** empty, parked and full are recomputed from slot_map every cycle, registered, so they lag slot_map by one cycle. parked + empty = 8 always.
- Requests arriving while busy are held by the requester and served on the next IDLE. No queueing inside the block.
- Reset values: state IDLE, slot_map 8'hFF, empty 8, parked 0, full 0. All acks, ok, entry_slot, gate_open and busy are 0. Last-served flag = entry.
- Reset asserted mid-transaction takes effect immediately and asynchronously. gate_open drops, the map returns to all-empty, and occupancy is lost by design.

## Timing
- Request seen in IDLE in cycle 0:
  - GRANT (ack) in cycle 1.
  - slot_map new value visible in cycle 1.
  - Counts updated in cycle 2.
- Accepted transaction: OPEN in cycles 2..GATE_CYCLES+1, CLOSE in cycle GATE_CYCLES+2, IDLE in cycle GATE_CYCLES+3. The next request can be sampled then.
- Rejected transaction: GRANT in cycle 1, CLOSE in cycle 2, IDLE in cycle 3. gate_open is never asserted.
- entry_ack and exit_ack are never high in the same cycle. gate_open is never high outside OPEN.
- exit_slot changes after sampling are ignored.

## Test plan
- **Reset:** release rst_n → slot_map = 0xFF, empty = 8, parked = 0, full = 0, gate_open = 0, busy = 0.
- **Single entry (GATE_CYCLES = 4):** entry_req in cycle 0 → cycle 1: entry_ack = 1, entry_ok = 1, entry_slot = 0, slot_map = 0xFE. Then:
  - Cycle 2: empty = 7, parked = 1.
  - Cycles 2–5: gate_open = 1.
  - Cycle 6: CLOSE.
  - Cycle 7: busy = 0.
- **Fill and reject:** 8 back-to-back entries → slots 0..7 assigned in order, slot_map = 0x00, full = 1. Ninth entry → entry_ok = 0, gate_open stays 0, busy low 3 cycles after the request.
- **Full with tie:** slot_map = 0x00, entry_req and exit_req (exit_slot = 3) together → exit served first, slot_map = 0x08. Then entry served with entry_slot = 3, slot_map = 0x00.
- **Alternation and exit error:**
  - From reset, hold both requests continuously, with exit_slot = 5 held → ack order is exit (ok = 0, slot 5 empty), entry (slot 0), exit (ok = 0).
  - Then exit_slot = 0 alone → exit_ok = 1, slot_map = 0xFF.
- **Reset mid-OPEN:** assert rst_n low during cycle 3 of an entry → gate_open = 0 and slot_map = 0xFF immediately. After release, the next entry is assigned slot 0.
